// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with first-word fall-through, TLAST sideband,
// optional store-and-forward packet gating, fill-level flags and a peak watermark.
module axis_sync_fifo #(
   parameter int DATA_WIDTH          = 16,
   parameter int FIFO_DEPTH          = 8,
   parameter int ALMOST_FULL_THRESH  = 6,
   parameter int ALMOST_EMPTY_THRESH = 2,
   parameter int PACKET_MODE         = 0
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tlast,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [$clog2(FIFO_DEPTH):0]   pkt_count,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [$clog2(FIFO_DEPTH):0]   peak_level,
   input  logic                          peak_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   // Entry layout: {tlast, tdata}
   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0] level_reg, level_next;
   logic [LW-1:0] pkt_reg, pkt_next;
   logic [LW-1:0] peak_reg, peak_next;
   logic          wr_fire, rd_fire;
   logic          head_last;
   logic          release_ok;
   logic          pkt_inc, pkt_dec;

   assign head_last    = mem[rd_ptr_reg][DATA_WIDTH];
   assign m_axis_tdata = mem[rd_ptr_reg][DATA_WIDTH-1:0];
   assign m_axis_tlast = head_last;

   // Store-and-forward holds the head back until a whole packet is stored,
   // except when full: an oversize packet must drain or nothing ever moves.
   generate
      if (PACKET_MODE != 0) begin : g_pkt_mode
         assign release_ok = (pkt_reg != '0) || (level_reg == LW'(FIFO_DEPTH));
      end else begin : g_cut_mode
         assign release_ok = 1'b1;
      end
   endgenerate

   assign s_axis_tready = !arst && !flush && (level_reg != LW'(FIFO_DEPTH));
   assign m_axis_tvalid = !arst && !flush && (level_reg != '0) && release_ok;

   assign wr_fire = s_axis_tvalid && s_axis_tready;
   assign rd_fire = m_axis_tvalid && m_axis_tready;
   assign pkt_inc = wr_fire && s_axis_tlast;
   assign pkt_dec = rd_fire && head_last;

   always_comb begin
      level_next = level_reg;
      if (wr_fire && !rd_fire) begin
         level_next = level_reg + LW'(1);
      end else if (rd_fire && !wr_fire) begin
         level_next = level_reg - LW'(1);
      end
   end

   always_comb begin
      pkt_next = pkt_reg;
      if (pkt_inc && !pkt_dec) begin
         pkt_next = pkt_reg + LW'(1);
      end else if (pkt_dec && !pkt_inc) begin
         pkt_next = pkt_reg - LW'(1);
      end
   end

   // Watermark samples the registered level, so it trails level by one cycle.
   always_comb begin
      peak_next = peak_reg;
      if (peak_clr) begin
         peak_next = level_reg;
      end else if (level_reg > peak_reg) begin
         peak_next = level_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         pkt_reg    <= '0;
         peak_reg   <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         pkt_reg    <= '0;
         peak_reg   <= peak_next;
      end else begin
         if (wr_fire) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg <= level_next;
         pkt_reg   <= pkt_next;
         peak_reg  <= peak_next;
      end
   end

   // Storage has no reset; wr_fire is already blocked during reset and flush.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr_reg] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   assign level        = level_reg;
   assign pkt_count    = pkt_reg;
   assign peak_level   = peak_reg;
   assign almost_full  = (level_reg >= LW'(ALMOST_FULL_THRESH));
   assign almost_empty = (level_reg <= LW'(ALMOST_EMPTY_THRESH));

endmodule
